// File: rtl/instr_encoder_if.sv
// ---------------------------------------------------------------------------
// instr_encoder_if
// Bundle input handshake plus instruction-memory write port of the
// instruction encoder.
//   master : front end that supplies field bundles (drives in_*, observes
//            in_ready and the memory write port)
//   slave  : the encoder itself
// Signals:
//   in_valid/in_ready           bundle handshake
//   in_op                       instruction class (0..9 legal)
//   in_rs/in_rt/in_rd/in_shamt  register and shift fields
//   in_funct                    R-type function code
//   in_imm                      I-type immediate
//   in_target                   J-type target
//   in_last                     bundle is the final instruction
//   imem_we/imem_addr/imem_wdata instruction memory write port
// ---------------------------------------------------------------------------
interface instr_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [4:0]        in_shamt;
    logic [5:0]        in_funct;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              in_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt,
               in_funct, in_imm, in_target, in_last,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_shamt,
               in_funct, in_imm, in_target, in_last,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
// Packs field bundles into 32-bit MIPS instruction words and writes them to
// consecutive instruction-memory addresses starting at BASE_ADDR.
// Ports:
//   clk, rst_n  clock (rising edge) and asynchronous active-low reset
//   start       pulse: (re)arm, pointer back to BASE_ADDR
//   bus         instr_encoder_if.slave: bundle handshake + imem write port
//   busy        high in ACCEPT or WRITE
//   done        high in DONE or ERROR
//   err         error flag; err_code 01 illegal class, 10 overflow,
//               11 illegal funct
//   word_count  words written since last start
// Optional build macro: ENCODER_FIELD_CHECK_EN -- restricts R-type funct to
// ADD/SUB/AND/OR/SLT; anything else is rejected with err_code 11.
// ---------------------------------------------------------------------------
module instr_encoder #(
    parameter int IMEM_DEPTH = 256,
    parameter int ADDR_W     = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    instr_encoder_if.slave      bus,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [1:0]          err_code,
    output logic [ADDR_W:0]     word_count
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE_ADDR + IMEM_DEPTH - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W+1)'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              last_q, last_d;
    logic              err_q, err_d;
    logic [1:0]        code_q, code_d;

    // Encoder for the bundle currently presented
    logic        class_ok;
    logic        funct_ok;
    logic [31:0] enc_word;

    always_comb begin
        class_ok = 1'b1;
        enc_word = '0;
        case (bus.in_op)
            4'd0: enc_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd,
                              bus.in_shamt, bus.in_funct};
            4'd1: enc_word = {6'b000010, bus.in_target};
            4'd2: enc_word = {6'b000100, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd3: enc_word = {6'b100011, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd4: enc_word = {6'b101011, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd5: enc_word = {6'b001000, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd6: enc_word = {6'b001010, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd7: enc_word = {6'b001100, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd8: enc_word = {6'b001101, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd9: enc_word = {6'b001110, bus.in_rs, bus.in_rt, bus.in_imm};
            default: class_ok = 1'b0;
        endcase
    end

`ifdef ENCODER_FIELD_CHECK_EN
    // Only the ALU functions the main decoder understands are allowed;
    // funct is irrelevant for every non-R class.
    always_comb begin
        funct_ok = 1'b1;
        if (bus.in_op == 4'd0) begin
            case (bus.in_funct)
                6'b100000, 6'b100010, 6'b100100,
                6'b100101, 6'b101010: funct_ok = 1'b1;
                default:              funct_ok = 1'b0;
            endcase
        end
    end
`else
    assign funct_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        last_d  = last_q;
        err_d   = err_q;
        code_d  = code_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR, S_ACCEPT: begin
                // start wins over a same-cycle bundle in ACCEPT
                if (start) begin
                    state_d = S_ACCEPT;
                    ptr_d   = FIRST_ADDR;
                    count_d = '0;
                    err_d   = 1'b0;
                    code_d  = 2'b00;
                end else if (state_q == S_ACCEPT && bus.in_valid) begin
                    if (!class_ok) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                        code_d  = 2'b01;
                    end else if (!funct_ok) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                        code_d  = 2'b11;
                    end else begin
                        state_d = S_WRITE;
                        addr_d  = ptr_q;
                        wdata_d = enc_word;
                        last_d  = bus.in_last;
                    end
                end
            end
            S_WRITE: begin
                // start is deliberately not looked at here
                ptr_d   = ptr_q + PTR_ONE;
                count_d = count_q + CNT_ONE;
                if (last_q) begin
                    state_d = S_DONE;
                end else if (ptr_q == LAST_ADDR) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    code_d  = 2'b10;
                end else begin
                    state_d = S_ACCEPT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= FIRST_ADDR;
            count_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign bus.in_ready   = (state_q == S_ACCEPT);
    assign bus.imem_we    = (state_q == S_WRITE);
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign busy           = (state_q == S_ACCEPT) || (state_q == S_WRITE);
    assign done           = (state_q == S_DONE) || (state_q == S_ERROR);
    assign err            = err_q;
    assign err_code       = code_q;
    assign word_count     = count_q;
endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    always #5 clk = ~clk;

    // shared bundle drive
    logic        in_valid = 1'b0;
    logic [3:0]  in_op = '0;
    logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
    logic [5:0]  in_funct = '0;
    logic [15:0] in_imm = '0;
    logic [25:0] in_target = '0;
    logic        in_last = 1'b0;
    bit          sel_b = 1'b0;

    instr_encoder_if #(.ADDR_W(8)) bus_a ();
    instr_encoder_if #(.ADDR_W(8)) bus_b ();

    assign bus_a.in_valid = in_valid;  assign bus_b.in_valid = in_valid;
    assign bus_a.in_op = in_op;        assign bus_b.in_op = in_op;
    assign bus_a.in_rs = in_rs;        assign bus_b.in_rs = in_rs;
    assign bus_a.in_rt = in_rt;        assign bus_b.in_rt = in_rt;
    assign bus_a.in_rd = in_rd;        assign bus_b.in_rd = in_rd;
    assign bus_a.in_shamt = in_shamt;  assign bus_b.in_shamt = in_shamt;
    assign bus_a.in_funct = in_funct;  assign bus_b.in_funct = in_funct;
    assign bus_a.in_imm = in_imm;      assign bus_b.in_imm = in_imm;
    assign bus_a.in_target = in_target; assign bus_b.in_target = in_target;
    assign bus_a.in_last = in_last;    assign bus_b.in_last = in_last;

    logic       busy_a, done_a, err_a, busy_b, done_b, err_b;
    logic [1:0] code_a, code_b;
    logic [8:0] cnt_a, cnt_b;

    instr_encoder #(.IMEM_DEPTH(256), .ADDR_W(8), .BASE_ADDR(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .bus(bus_a),
        .busy(busy_a), .done(done_a), .err(err_a), .err_code(code_a),
        .word_count(cnt_a)
    );

    instr_encoder #(.IMEM_DEPTH(4), .ADDR_W(8), .BASE_ADDR(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .bus(bus_b),
        .busy(busy_b), .done(done_b), .err(err_b), .err_code(code_b),
        .word_count(cnt_b)
    );

    int checks = 0;
    int failures = 0;
    int cycle = 0;
    logic [7:0]  wr_addr[$];
    logic [31:0] wr_data[$];

    always @(posedge clk) cycle <= cycle + 1;

    // capture memory writes mid-cycle, one line per write
    always @(negedge clk) begin
        if (bus_a.imem_we) begin
            wr_addr.push_back(bus_a.imem_addr);
            wr_data.push_back(bus_a.imem_wdata);
            $display("write A addr=%0d data=%08h", bus_a.imem_addr, bus_a.imem_wdata);
        end
        if (bus_b.imem_we) begin
            wr_addr.push_back(bus_b.imem_addr);
            wr_data.push_back(bus_b.imem_wdata);
            $display("write B addr=%0d data=%08h", bus_b.imem_addr, bus_b.imem_wdata);
        end
    end

    task automatic do_start(input bit b);
        @(negedge clk);
        if (b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic set_bundle(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [5:0] funct,
                              input logic [15:0] imm, input logic [25:0] tgt, input logic last);
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = '0;
        in_funct = funct; in_imm = imm; in_target = tgt; in_last = last;
        in_valid = 1'b1;
    endtask

    // waits (bounded) for a handshake; returns just after the accepting edge
    task automatic wait_accept(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sel_b ? bus_b.in_ready : bus_a.in_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({busy_a, done_a, err_a, code_a, cnt_a, bus_a.in_ready, bus_a.imem_we,
             bus_a.imem_addr, bus_a.imem_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b done=%b err=%b code=%b cnt=%0d rdy=%b we=%b addr=%h data=%h, required all 0",
                     busy_a, done_a, err_a, code_a, cnt_a, bus_a.in_ready, bus_a.imem_we,
                     bus_a.imem_addr, bus_a.imem_wdata);
        end
    endtask

    task automatic test_single_r();
        bit ok;
        wr_addr.delete(); wr_data.delete();
        sel_b = 1'b0;
        do_start(1'b0);
        checks++;
        if (busy_a !== 1'b1 || bus_a.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL start_arm: busy=%b in_ready=%b, required 1 1", busy_a, bus_a.in_ready);
        end
        set_bundle(4'd0, 5'd1, 5'd2, 5'd3, 6'b100000, 16'h0, 26'h0, 1'b1);
        wait_accept(ok);
        in_valid = 1'b0;
        checks++;
        if (!ok || bus_a.imem_we !== 1'b1) begin
            failures++;
            $display("FAIL single_we: accepted=%b we=%b, required 1 1", ok, bus_a.imem_we);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (wr_addr.size() != 1 || wr_addr[0] !== 8'd0 || wr_data[0] !== 32'h00221820) begin
            failures++;
            $display("FAIL single_write: n=%0d addr=%0d data=%08h, required 1 0 00221820",
                     wr_addr.size(), wr_addr.size() > 0 ? wr_addr[0] : 8'hxx,
                     wr_data.size() > 0 ? wr_data[0] : 32'hx);
        end
        checks++;
        if (done_a !== 1'b1 || err_a !== 1'b0 || cnt_a !== 9'd1 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL single_done: done=%b err=%b cnt=%0d busy=%b, required 1 0 1 0",
                     done_a, err_a, cnt_a, busy_a);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int prev;
        logic [3:0]  ops[5]  = '{4'd5, 4'd3, 4'd4, 4'd2, 4'd1};
        logic [4:0]  rss[5]  = '{5'd0, 5'd1, 5'd1, 5'd1, 5'd0};
        logic [4:0]  rts[5]  = '{5'd1, 5'd2, 5'd3, 5'd2, 5'd0};
        logic [15:0] imms[5] = '{16'h0005, 16'h0004, 16'h0008, 16'hFFFF, 16'h0};
        logic [31:0] exp[5]  = '{32'h20010005, 32'h8C220004, 32'hAC230008,
                                 32'h1022FFFF, 32'h08000010};
        wr_addr.delete(); wr_data.delete();
        sel_b = 1'b0;
        prev = 0;
        do_start(1'b0);
        for (int i = 0; i < 5; i++) begin
            set_bundle(ops[i], rss[i], rts[i], 5'd0, 6'd0, imms[i], 26'h10, i == 4);
            wait_accept(ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL b2b_accept%0d: not accepted within bound", i);
            end
            if (i > 0) begin
                checks++;
                if (cycle - prev != 2) begin
                    failures++;
                    $display("FAIL b2b_gap%0d: %0d cycles between accepts, required 2", i, cycle - prev);
                end
            end
            prev = cycle;
            @(negedge clk);
            checks++;
            if (bus_a.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL b2b_ready_low%0d: in_ready=%b in WRITE, required 0", i, bus_a.in_ready);
            end
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (wr_addr.size() != 5) begin
            failures++;
            $display("FAIL b2b_nwrites: %0d, required 5", wr_addr.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (wr_addr[i] !== 8'(i) || wr_data[i] !== exp[i]) begin
                    failures++;
                    $display("FAIL b2b_word%0d: addr=%0d data=%08h, required %0d %08h",
                             i, wr_addr[i], wr_data[i], i, exp[i]);
                end
            end
        end
        checks++;
        if (done_a !== 1'b1 || err_a !== 1'b0 || cnt_a !== 9'd5) begin
            failures++;
            $display("FAIL b2b_done: done=%b err=%b cnt=%0d, required 1 0 5", done_a, err_a, cnt_a);
        end
    endtask

    task automatic test_illegal_class();
        bit ok;
        wr_addr.delete(); wr_data.delete();
        sel_b = 1'b0;
        do_start(1'b0);
        set_bundle(4'd6, 5'd2, 5'd3, 5'd0, 6'd0, 16'h00FF, 26'h0, 1'b0);
        wait_accept(ok);
        set_bundle(4'd7, 5'd4, 5'd5, 5'd0, 6'd0, 16'h1234, 26'h0, 1'b0);
        wait_accept(ok);
        set_bundle(4'd12, 5'd1, 5'd1, 5'd0, 6'd0, 16'h1, 26'h0, 1'b1);
        wait_accept(ok);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (wr_addr.size() != 2 || wr_data[0] !== 32'h284300FF || wr_data[1] !== 32'h30851234) begin
            failures++;
            $display("FAIL illegal_writes: n=%0d, required 2 words 284300FF 30851234", wr_addr.size());
        end
        checks++;
        if (done_a !== 1'b1 || err_a !== 1'b1 || code_a !== 2'b01 || cnt_a !== 9'd2 ||
            bus_a.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL illegal_state: done=%b err=%b code=%b cnt=%0d rdy=%b, required 1 1 01 2 0",
                     done_a, err_a, code_a, cnt_a, bus_a.in_ready);
        end
        do_start(1'b0);
        checks++;
        if (busy_a !== 1'b1 || done_a !== 1'b0 || err_a !== 1'b0 || code_a !== 2'b00 ||
            cnt_a !== 9'd0) begin
            failures++;
            $display("FAIL rearm_clear: busy=%b done=%b err=%b code=%b cnt=%0d, required 1 0 0 00 0",
                     busy_a, done_a, err_a, code_a, cnt_a);
        end
        wr_addr.delete(); wr_data.delete();
        set_bundle(4'd8, 5'd1, 5'd1, 5'd0, 6'd0, 16'hABCD, 26'h0, 1'b1);
        wait_accept(ok);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (wr_addr.size() != 1 || wr_addr[0] !== 8'd0 || wr_data[0] !== 32'h3421ABCD) begin
            failures++;
            $display("FAIL rearm_write: n=%0d, required one word 3421ABCD at addr 0", wr_addr.size());
        end
    endtask

    task automatic test_overflow();
        bit ok;
        wr_addr.delete(); wr_data.delete();
        sel_b = 1'b1;
        do_start(1'b1);
        for (int i = 0; i < 6; i++) begin
            set_bundle(4'd9, 5'd0, 5'd0, 5'd0, 6'd0, 16'(i), 26'h0, 1'b0);
            wait_accept(ok);
            if (i < 4 || i == 4) begin
                checks++;
                if (ok !== (i < 4)) begin
                    failures++;
                    $display("FAIL overflow_accept%0d: accepted=%b, required %b", i, ok, i < 4);
                end
            end
        end
        in_valid = 1'b0;
        sel_b = 1'b0;
        checks++;
        if (wr_addr.size() != 4) begin
            failures++;
            $display("FAIL overflow_nwrites: %0d, required 4", wr_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_addr[i] !== 8'(i) || wr_data[i] !== (32'h38000000 | 32'(i))) begin
                    failures++;
                    $display("FAIL overflow_word%0d: addr=%0d data=%08h, required %0d %08h",
                             i, wr_addr[i], wr_data[i], i, 32'h38000000 | 32'(i));
                end
            end
        end
        checks++;
        if (done_b !== 1'b1 || err_b !== 1'b1 || code_b !== 2'b10 || cnt_b !== 9'd4) begin
            failures++;
            $display("FAIL overflow_state: done=%b err=%b code=%b cnt=%0d, required 1 1 10 4",
                     done_b, err_b, code_b, cnt_b);
        end
    endtask

    task automatic test_reset_mid_write();
        bit ok;
        sel_b = 1'b0;
        do_start(1'b0);
        set_bundle(4'd5, 5'd0, 5'd7, 5'd0, 6'd0, 16'h0077, 26'h0, 1'b0);
        wait_accept(ok);
        in_valid = 1'b0;
        checks++;
        if (!ok || bus_a.imem_we !== 1'b1) begin
            failures++;
            $display("FAIL rstw_in_write: accepted=%b we=%b, required 1 1", ok, bus_a.imem_we);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_a, done_a, err_a, code_a, cnt_a, bus_a.in_ready, bus_a.imem_we,
             bus_a.imem_addr, bus_a.imem_wdata} !== '0) begin
            failures++;
            $display("FAIL rstw_outputs: busy=%b done=%b we=%b addr=%h data=%h cnt=%0d, required all 0",
                     busy_a, done_a, bus_a.imem_we, bus_a.imem_addr, bus_a.imem_wdata, cnt_a);
        end
        #12;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus_a.in_ready !== 1'b0 || busy_a !== 1'b0) begin
                failures++;
                $display("FAIL rstw_idle%0d: in_ready=%b busy=%b, required 0 0", i, bus_a.in_ready, busy_a);
            end
        end
    endtask

    task automatic test_funct_check();
        bit ok;
        wr_addr.delete(); wr_data.delete();
        sel_b = 1'b0;
        do_start(1'b0);
        set_bundle(4'd0, 5'd1, 5'd2, 5'd3, 6'b100111, 16'h0, 26'h0, 1'b1);
        wait_accept(ok);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
`ifdef ENCODER_FIELD_CHECK_EN
        checks++;
        if (wr_addr.size() != 0 || err_a !== 1'b1 || code_a !== 2'b11 || done_a !== 1'b1) begin
            failures++;
            $display("FAIL funct_reject: n=%0d err=%b code=%b done=%b, required 0 1 11 1",
                     wr_addr.size(), err_a, code_a, done_a);
        end
`else
        checks++;
        if (wr_addr.size() != 1 || wr_data[0] !== 32'h00221827 || err_a !== 1'b0 ||
            done_a !== 1'b1) begin
            failures++;
            $display("FAIL funct_pass: n=%0d err=%b done=%b, required one word 00221827, err 0, done 1",
                     wr_addr.size(), err_a, done_a);
        end
`endif
    endtask

    initial begin
        #17;
        test_reset();
        rst_n = 1'b1;
        test_single_r();
        test_back_to_back();
        test_illegal_class();
        test_overflow();
        test_reset_mid_write();
        test_funct_check();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
